// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants.
package pipeline_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Registered synchronous FIFO with flush; head is read straight from storage (no bypass).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        rdata   = mem_q[rd_ptr_q];
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC ownership, credit-limited imem requests, wrong-path response dropping.
module instr_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned     XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            accept, id_pop, rsp_keep, rsp_drop;
    logic [CW:0]     credits_used;

    logic [XLEN-1:0] pcq_head;
    logic [CW-1:0]   pcq_count;
    logic            pcq_full, pcq_empty;

    logic [XLEN+31:0] ifq_head;
    logic [CW-1:0]    ifq_count;
    logic             ifq_full, ifq_empty;

    logic unused_bits;

    always_comb begin
        id_pop       = id_valid && id_ready;
        credits_used = {1'b0, outstanding_q} + {1'b0, drop_cnt_q} + {1'b0, ifq_count}
                     - (CW+1)'(id_pop);
        imem_req_valid = rst_n && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
        imem_req_addr  = pc_q;
        accept         = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
        rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0);
    end

    always_comb begin
        id_valid    = !ifq_empty;
        id_instr    = id_valid ? ifq_head[31:0]      : NOP_INSTR;
        id_pc       = id_valid ? ifq_head[XLEN+31:32] : '0;
        id_pc_plus4 = id_pc + XLEN'(4);
    end

    // On redirect every in-flight request, including any response arriving now, becomes a drop.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            pc_d          = {redirect_pc[XLEN-1:2], 2'b00};
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_keep);
            drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (pc_q),
        .pop   (rsp_keep),
        .flush (redirect_valid),
        .rdata (pcq_head),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    sync_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_instr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep && !redirect_valid),
        .wdata ({pcq_head, imem_rsp_data}),
        .pop   (id_pop),
        .flush (redirect_valid),
        .rdata (ifq_head),
        .count (ifq_count),
        .full  (ifq_full),
        .empty (ifq_empty)
    );

    assign unused_bits = ^{pcq_count, pcq_full, pcq_empty, ifq_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: in-order memory model with variable latency.
module tb_instr_fetch_unit;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          dropped;
    } mem_txn_t;

    mem_txn_t     mem_q[$];
    fetch_entry_t exp_q[$];
    int           cyc, last_due;
    int           lat_min = 1, lat_max = 1;
    logic [31:0]  exp_pc;
    int           n_checks = 0, n_fail = 0;
    int           pop_cnt = 0, acc_cnt = 0;
    logic [31:0]  last_pop_pc, last_pop_p4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Observe at negedge what the coming edge will do, advance, then drive the memory response.
    task automatic step();
        mem_txn_t     m;
        fetch_entry_t e;
        int           d;
        @(negedge clk);
        if (!rst_n) begin
            mem_q.delete();
            exp_q.delete();
            exp_pc   = 32'h0;
            last_due = 0;
            cyc      = -1;
        end else begin
            if (!id_valid) check_eq("nop_when_idle", id_instr, NOP_INSTR);
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_pop_pc", id_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("id_pc", id_pc, e.pc);
                    check_eq("id_instr", id_instr, e.instr);
                    check_eq("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
                    pop_cnt++;
                    last_pop_pc = id_pc;
                    last_pop_p4 = id_pc_plus4;
                end
            end
            if (imem_rsp_valid) begin
                m = mem_q.pop_front();
                if (!m.dropped && !redirect_valid)
                    exp_q.push_back('{pc: m.addr, instr: mem_word(m.addr)});
            end
            if (redirect_valid) begin
                check_eq("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
                foreach (mem_q[i]) mem_q[i].dropped = 1'b1;
                exp_q.delete();
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (imem_req_valid) begin
                check_eq("req_addr", imem_req_addr, exp_pc);
                if (imem_req_ready) begin
                    d = cyc + int'($urandom_range(lat_max, lat_min));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    mem_q.push_back('{addr: imem_req_addr, due: d, dropped: 1'b0});
                    exp_pc = exp_pc + 32'd4;
                    acc_cnt++;
                end
            end
            check_eq("inflight_le_depth", 32'(mem_q.size() <= DEPTH), 32'd1);
            check_eq("credits_le_depth", 32'(mem_q.size() + exp_q.size() <= DEPTH), 32'd1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) step();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_id_instr", id_instr, NOP_INSTR);
        rst_n = 1'b1;
        #1;
        check_eq("rel_req_addr", imem_req_addr, 32'h0);
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] pc, input logic [31:0] p4);
        int p0 = pop_cnt;
        int n  = 0;
        while (pop_cnt == p0 && n < 60) begin
            step();
            n++;
        end
        check_eq({tag, "_seen"}, 32'(pop_cnt != p0), 32'd1);
        check_eq({tag, "_pc"}, last_pop_pc, pc);
        check_eq({tag, "_p4"}, last_pop_p4, p4);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        while ((mem_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        step();
        check_eq({tag, "_empty"}, 32'(mem_q.size() + exp_q.size()), 32'd0);
        check_eq({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        imem_req_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, a0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        cyc            = -1;

        // Reset release latency and full throughput with 1-cycle memory.
        repeat (3) step();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_id_instr", id_instr, NOP_INSTR);
        rst_n = 1'b1;
        #1;
        check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("first_req_addr", imem_req_addr, 32'h0);
        step();
        check_eq("id_valid_c1", 32'(id_valid), 32'd0);
        step();
        check_eq("id_valid_c2", 32'(id_valid), 32'd1);
        check_eq("id_pc_c2", id_pc, 32'h0);
        p0 = pop_cnt;
        repeat (20) step();
        check_eq("throughput", 32'(pop_cnt - p0), 32'd20);
        drain("t1_drain");

        // Decode stall: credits cap issue at DEPTH, nothing lost on resume.
        do_reset();
        id_ready = 1'b0;
        a0 = acc_cnt;
        p0 = pop_cnt;
        repeat (10) step();
        check_eq("stall_accepts", 32'(acc_cnt - a0), DEPTH);
        check_eq("stall_req_low", 32'(imem_req_valid), 32'd0);
        drain("stall_drain");
        check_eq("stall_no_loss", 32'(pop_cnt - p0), DEPTH);

        // Redirect with two requests in flight (3-cycle memory).
        do_reset();
        lat_min = 3;
        lat_max = 3;
        step();
        step();
        check_eq("two_inflight", 32'(mem_q.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        wait_pop("redir100", 32'h100, 32'h104);
        lat_min = 1;
        lat_max = 1;

        // Misaligned target, then back-to-back redirects.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("align_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("align_req_addr", imem_req_addr, 32'h200);
        wait_pop("redir203", 32'h200, 32'h204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("b2b_req_addr", imem_req_addr, 32'h400);
        wait_pop("b2b", 32'h400, 32'h404);

        // Address wrap at the top of the space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_pop("wrap_top", 32'hFFFF_FFFC, 32'h0);
        wait_pop("wrap_zero", 32'h0, 32'h4);
        drain("t4_drain");

        // Random ready, latency 1-5, decode stalls and occasional redirects.
        lat_min = 1;
        lat_max = 5;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            id_ready       = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(29, 0) == 0);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        drain("rand_drain");

        // Reset in the middle of a burst.
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        repeat (8) step();
        rst_n = 1'b0;
        step();
        check_eq("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("midrst_id_valid", 32'(id_valid), 32'd0);
        check_eq("midrst_id_instr", id_instr, NOP_INSTR);
        rst_n = 1'b1;
        #1;
        check_eq("midrst_req_addr", imem_req_addr, 32'h0);
        wait_pop("midrst_first", 32'h0, 32'h4);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
